// File: rtl/axi_pkg.sv
// Shared encodings for the AXI4 read crossbar: response codes, burst types and FSM states.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        DECERR = 2'd3
    } xbar_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back toward ptr so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_xbar.sv
// AXI4 read-path crossbar: NUM_M masters to NUM_S slaves plus an internal DECERR slave,
// one transaction in flight, round-robin master arbitration.
//   state  | meaning
//   IDLE   | no transaction; arbitrate and decode on any ARVALID_M
//   ADDR   | AR of granted master presented to the selected slave (or absorbed if unmapped)
//   DATA   | R beats of the selected slave routed to the granted master
//   DECERR | internal slave returns ARLEN+1 beats with DECERR
module axi_read_xbar
    import axi_pkg::*;
#(
    parameter  int                      NUM_M    = 2,
    parameter  int                      NUM_S    = 2,
    parameter  int                      ADDR_W   = 32,
    parameter  int                      DATA_W   = 32,
    parameter  int                      ID_W     = 4,
    parameter  int                      LEN_W    = 4,
    parameter  logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter  logic [NUM_S*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    localparam int                      GNT_W    = $clog2(NUM_M),
    localparam int                      IDS_W    = ID_W + GNT_W
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_M*ID_W-1:0]     ARID_M,
    input  logic [NUM_M*ADDR_W-1:0]   ARADDR_M,
    input  logic [NUM_M*LEN_W-1:0]    ARLEN_M,
    input  logic [NUM_M*3-1:0]        ARSIZE_M,
    input  logic [NUM_M*2-1:0]        ARBURST_M,
    input  logic [NUM_M-1:0]          ARVALID_M,
    output logic [NUM_M-1:0]          ARREADY_M,
    output logic [NUM_M*ID_W-1:0]     RID_M,
    output logic [NUM_M*DATA_W-1:0]   RDATA_M,
    output logic [NUM_M*2-1:0]        RRESP_M,
    output logic [NUM_M-1:0]          RLAST_M,
    output logic [NUM_M-1:0]          RVALID_M,
    input  logic [NUM_M-1:0]          RREADY_M,
    output logic [NUM_S*IDS_W-1:0]    ARID_S,
    output logic [NUM_S*ADDR_W-1:0]   ARADDR_S,
    output logic [NUM_S*LEN_W-1:0]    ARLEN_S,
    output logic [NUM_S*3-1:0]        ARSIZE_S,
    output logic [NUM_S*2-1:0]        ARBURST_S,
    output logic [NUM_S-1:0]          ARVALID_S,
    input  logic [NUM_S-1:0]          ARREADY_S,
    input  logic [NUM_S*IDS_W-1:0]    RID_S,
    input  logic [NUM_S*DATA_W-1:0]   RDATA_S,
    input  logic [NUM_S*2-1:0]        RRESP_S,
    input  logic [NUM_S-1:0]          RLAST_S,
    input  logic [NUM_S-1:0]          RVALID_S,
    output logic [NUM_S-1:0]          RREADY_S
);

    // sel encodes slaves 0..NUM_S-1, with NUM_S meaning the internal DECERR slave.
    localparam int                SEL_W       = $clog2(NUM_S + 1);
    localparam int                SIDX_W      = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam logic [SEL_W-1:0]  SEL_DEFAULT = SEL_W'(NUM_S);

    logic [NUM_M-1:0][ID_W-1:0]   arid_m;
    logic [NUM_M-1:0][ADDR_W-1:0] araddr_m;
    logic [NUM_M-1:0][LEN_W-1:0]  arlen_m;
    logic [NUM_M-1:0][2:0]        arsize_m;
    logic [NUM_M-1:0][1:0]        arburst_m;
    logic [NUM_M-1:0][ID_W-1:0]   rid_m;
    logic [NUM_M-1:0][DATA_W-1:0] rdata_m;
    logic [NUM_M-1:0][1:0]        rresp_m;

    logic [NUM_S-1:0][IDS_W-1:0]  arid_s;
    logic [NUM_S-1:0][ADDR_W-1:0] araddr_s;
    logic [NUM_S-1:0][LEN_W-1:0]  arlen_s;
    logic [NUM_S-1:0][2:0]        arsize_s;
    logic [NUM_S-1:0][1:0]        arburst_s;
    logic [NUM_S-1:0][IDS_W-1:0]  rid_s;
    logic [NUM_S-1:0][DATA_W-1:0] rdata_s;
    logic [NUM_S-1:0][1:0]        rresp_s;

    assign arid_m    = ARID_M;
    assign araddr_m  = ARADDR_M;
    assign arlen_m   = ARLEN_M;
    assign arsize_m  = ARSIZE_M;
    assign arburst_m = ARBURST_M;
    assign rid_s     = RID_S;
    assign rdata_s   = RDATA_S;
    assign rresp_s   = RRESP_S;

    assign RID_M     = rid_m;
    assign RDATA_M   = rdata_m;
    assign RRESP_M   = rresp_m;
    assign ARID_S    = arid_s;
    assign ARADDR_S  = araddr_s;
    assign ARLEN_S   = arlen_s;
    assign ARSIZE_S  = arsize_s;
    assign ARBURST_S = arburst_s;

    xbar_state_e       state_q, state_d;
    logic [GNT_W-1:0]  rr_ptr_q;
    logic [GNT_W-1:0]  grant_q;
    logic [SEL_W-1:0]  sel_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [ID_W-1:0]   arid_q;

    logic [GNT_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [SEL_W-1:0]  dec_sel;
    logic [SIDX_W-1:0] s_idx;
    logic              sel_is_map;
    logic              r_last_hs;
    logic [GNT_W-1:0]  rr_next;
    logic              unused_rid_hi;

    rr_arbiter #(
        .N (NUM_M)
    ) u_arb (
        .req     (ARVALID_M),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Ascending priority: the lowest-indexed matching slave is assigned last and wins.
    always_comb begin
        dec_sel = SEL_DEFAULT;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((araddr_m[arb_idx] & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                dec_sel = SEL_W'(i);
        end
    end

    assign s_idx      = sel_q[SIDX_W-1:0];
    assign sel_is_map = (sel_q != SEL_DEFAULT);
    assign r_last_hs  = RVALID_S[s_idx] & RREADY_M[grant_q] & RLAST_S[s_idx];
    assign rr_next    = (grant_q == GNT_W'(NUM_M - 1)) ? '0 : grant_q + GNT_W'(1);

    // Slave-side RID carries the grant index in its upper bits; only the low ID_W bits return.
    always_comb begin
        unused_rid_hi = 1'b0;
        for (int s = 0; s < NUM_S; s++)
            unused_rid_hi = unused_rid_hi ^ (^rid_s[s][IDS_W-1:ID_W]);
    end

    always_comb begin
        state_d   = state_q;
        ARREADY_M = '0;
        RVALID_M  = '0;
        RLAST_M   = '0;
        rid_m     = '0;
        rdata_m   = '0;
        rresp_m   = '0;
        ARVALID_S = '0;
        RREADY_S  = '0;
        arid_s    = '0;
        araddr_s  = '0;
        arlen_s   = '0;
        arsize_s  = '0;
        arburst_s = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld)
                    state_d = ADDR;
            end
            ADDR: begin
                if (sel_is_map) begin
                    for (int s = 0; s < NUM_S; s++) begin
                        arid_s[s]    = {grant_q, arid_m[grant_q]};
                        araddr_s[s]  = araddr_m[grant_q];
                        arlen_s[s]   = arlen_m[grant_q];
                        arsize_s[s]  = arsize_m[grant_q];
                        arburst_s[s] = arburst_m[grant_q];
                    end
                    ARVALID_S[s_idx]   = 1'b1;
                    ARREADY_M[grant_q] = ARREADY_S[s_idx];
                    if (ARREADY_S[s_idx])
                        state_d = DATA;
                end else begin
                    ARREADY_M[grant_q] = 1'b1;
                    state_d            = DECERR;
                end
            end
            DATA: begin
                RVALID_M[grant_q] = RVALID_S[s_idx];
                RLAST_M[grant_q]  = RLAST_S[s_idx];
                rid_m[grant_q]    = rid_s[s_idx][ID_W-1:0];
                rdata_m[grant_q]  = rdata_s[s_idx];
                rresp_m[grant_q]  = rresp_s[s_idx];
                RREADY_S[s_idx]   = RREADY_M[grant_q];
                if (r_last_hs)
                    state_d = IDLE;
            end
            DECERR: begin
                RVALID_M[grant_q] = 1'b1;
                RLAST_M[grant_q]  = (beat_cnt_q == '0);
                rid_m[grant_q]    = arid_q;
                rresp_m[grant_q]  = RESP_DECERR;
                if (RREADY_M[grant_q] && (beat_cnt_q == '0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            arid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        grant_q <= arb_idx;
                        sel_q   <= dec_sel;
                    end
                end
                ADDR: begin
                    if (!sel_is_map) begin
                        beat_cnt_q <= arlen_m[grant_q];
                        arid_q     <= arid_m[grant_q];
                    end
                end
                DATA: begin
                    if (r_last_hs)
                        rr_ptr_q <= rr_next;
                end
                DECERR: begin
                    if (RREADY_M[grant_q]) begin
                        if (beat_cnt_q == '0)
                            rr_ptr_q <= rr_next;
                        else
                            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
